baud_tick_gen: RTL

Programmable tick generator for the UART receive path. It produces a one-cycle `tick` every `div_q + 1` enabled clock cycles, plus a `half_tick` at the midpoint of each period for centre-of-bit sampling. The divisor is runtime-loadable with a compile-time default. A `restart` input realigns the phase to a start-bit edge, and a one-shot mode stops the counter after a single period. The receiver FSM instantiates it as its bit-timing source.

---
 rtl/uart_timing_pkg.sv | 12 +
 rtl/baud_tick_gen.sv | 75 +++++++
 2 files changed

// File: rtl/uart_timing_pkg.sv
// Shared UART timing constants.
// Default divisor is derived from the system clock and baud rate.
package uart_timing_pkg;

    localparam int CLK_HZ      = 50_000_000;
    localparam int BAUD        = 115_200;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = CLK_HZ / BAUD - 1;

    typedef logic [DIV_W-1:0] div_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Programmable bit-timing source for the UART receiver.
// Emits tick every div_q+1 enabled cycles and half_tick mid-period.
module baud_tick_gen #(
    parameter int WIDTH       = uart_timing_pkg::DIV_W,
    parameter int DEFAULT_DIV = uart_timing_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             restart,
    input  logic             oneshot,
    output logic             tick,
    output logic             half_tick,
    output logic             active
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] div_q;
    logic             armed_q;
    logic             tick_q;
    logic             half_q;

    logic at_end;
    logic at_half;

    // Terminal and midpoint compares; count never passes div_q.
    always_comb begin
        at_end  = (count_q == div_q);
        at_half = (count_q == (div_q >> 1));
    end

    // Counter, divisor and arm state; load beats restart beats counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            div_q   <= WIDTH'(DEFAULT_DIV);
            armed_q <= 1'b1;
            tick_q  <= 1'b0;
            half_q  <= 1'b0;
        end else if (load) begin
            div_q   <= div_in;
            count_q <= '0;
            armed_q <= 1'b1;
            tick_q  <= 1'b0;
            half_q  <= 1'b0;
        end else if (restart) begin
            count_q <= '0;
            armed_q <= 1'b1;
            tick_q  <= 1'b0;
            half_q  <= 1'b0;
        end else if (en && armed_q) begin
            half_q <= at_half;
            if (at_end) begin
                count_q <= '0;
                tick_q  <= 1'b1;
                if (oneshot) begin
                    armed_q <= 1'b0;
                end
            end else begin
                count_q <= count_q + 1'b1;
                tick_q  <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
            half_q <= 1'b0;
        end
    end

    assign tick      = tick_q;
    assign half_tick = half_q;
    assign active    = armed_q;

endmodule
